updown_tick_counter: RTL and testbench

// - Up/down modulo counter advanced by the slow divided clock from the clock divider, which runs in the clock_in domain.
// - Samples clock_slow as data, never as a clock: synchronizer, then rising-edge detect, giving a 1-cycle step pulse.
// - Drives the digit/LED display path of the up/down counter design.
// - Supports load, direction select and a terminal-count pulse for cascading digits.

---
 rtl/updown_tick_counter_if.sv | 23 ++
 rtl/updown_tick_counter.sv | 86 ++++++++
 tb/tb_updown_tick_counter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/updown_tick_counter_if.sv
// Control/status bundle for updown_tick_counter: divided clock, mode controls, count and pulses.
interface updown_tick_counter_if #(
   parameter int WIDTH = 4
);
   logic             clock_slow;
   logic             enable;
   logic             up_down;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic [WIDTH-1:0] count;
   logic             terminal;
   logic             step_seen;

   modport master (
      output clock_slow, enable, up_down, load, load_value,
      input  count, terminal, step_seen
   );

   modport slave (
      input  clock_slow, enable, up_down, load, load_value,
      output count, terminal, step_seen
   );
endinterface

// File: rtl/updown_tick_counter.sv
// Up/down modulo counter stepped by rising edges of clock_slow, sampled as data in the clock_in domain.
// Define UPDOWN_HOLD_AT_LIMIT_EN for a saturating counter instead of wrap-around.
module updown_tick_counter #(
   parameter int WIDTH       = 4,
   parameter int MAX_COUNT   = 9,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clock_in,
   input  logic                  reset,
   updown_tick_counter_if.slave  bus
);
   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_COUNT);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] fill_q;
   logic                   prev_q;
   logic                   armed_q, armed_d;
   logic [WIDTH-1:0]       count_q, count_d;
   logic                   term_q, term_d;
   logic                   seen_q;
   logic                   s_last;
   logic                   step;

   // armed blocks a fake rise when clock_slow was already high at reset: it is
   // seeded from the raw level at the reset edge and set by the first genuine
   // low once the chain holds only post-reset samples (fill_q).
   assign s_last  = sync_q[SYNC_STAGES-1];
   assign step    = s_last & ~prev_q & armed_q;
   assign armed_d = armed_q | (fill_q[SYNC_STAGES-1] & ~s_last);

   always_comb begin
      count_d = count_q;
      term_d  = 1'b0;
      if (bus.load) begin
         count_d = (bus.load_value > MAXV) ? MAXV : bus.load_value;
      end else if (step && bus.enable) begin
         if (bus.up_down) begin
            if (count_q == MAXV) begin
               term_d = 1'b1;
`ifdef UPDOWN_HOLD_AT_LIMIT_EN
               count_d = MAXV;
`else
               count_d = '0;
`endif
            end else begin
               count_d = count_q + 1'b1;
            end
         end else begin
            if (count_q == '0) begin
               term_d = 1'b1;
`ifdef UPDOWN_HOLD_AT_LIMIT_EN
               count_d = '0;
`else
               count_d = MAXV;
`endif
            end else begin
               count_d = count_q - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock_in) begin
      if (reset) begin
         sync_q  <= '0;
         fill_q  <= '0;
         prev_q  <= 1'b0;
         armed_q <= ~bus.clock_slow;
         count_q <= '0;
         term_q  <= 1'b0;
         seen_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.clock_slow};
         fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
         prev_q  <= s_last;
         armed_q <= armed_d;
         count_q <= count_d;
         term_q  <= term_d;
         seen_q  <= step;
      end
   end

   assign bus.count     = count_q;
   assign bus.terminal  = term_q;
   assign bus.step_seen = seen_q;
endmodule

// File: tb/tb_updown_tick_counter.sv
// Randomized + directed bench for updown_tick_counter against a sample-history reference model.
module tb_updown_tick_counter;
   localparam int WIDTH = 4;
   localparam int MAXC  = 9;
   localparam int SYNC  = 2;
`ifdef UPDOWN_HOLD_AT_LIMIT_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   updown_tick_counter_if #(.WIDTH(WIDTH)) bus ();

   updown_tick_counter #(.WIDTH(WIDTH), .MAX_COUNT(MAXC), .SYNC_STAGES(SYNC)) dut (
      .clock_in (clk),
      .reset    (rst),
      .bus      (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: a step lands SYNC edges after the first high sample that
   // follows a low sample, provided no reset edge falls after that low sample.
   bit model_ok = 1'b0;
   int m_cnt = 0;
   bit m_term = 1'b0;
   bit m_seen = 1'b0;
   bit hcs[$];
   bit hrst[$];

   initial begin
      int  last, k;
      bit  stp;
      forever begin
         @(posedge clk);
         hcs.push_back(bus.clock_slow === 1'b1);
         hrst.push_back(rst === 1'b1);
         if (hcs.size() > 8) begin
            void'(hcs.pop_front());
            void'(hrst.pop_front());
         end
         last = hcs.size() - 1;
         stp  = 1'b0;
         if (last >= SYNC + 1) begin
            k   = last - SYNC;
            stp = hcs[k] && !hcs[k-1];
            for (int j = k; j <= last; j++) if (hrst[j]) stp = 1'b0;
         end
         if (rst) begin
            m_cnt = 0; m_term = 1'b0; m_seen = 1'b0; model_ok = 1'b1;
         end else begin
            m_seen = stp;
            m_term = 1'b0;
            if (bus.load) begin
               m_cnt = (int'(bus.load_value) > MAXC) ? MAXC : int'(bus.load_value);
            end else if (stp && bus.enable) begin
               if (bus.up_down) begin
                  if (m_cnt == MAXC) begin m_term = 1'b1; m_cnt = HOLD ? MAXC : 0; end
                  else m_cnt = m_cnt + 1;
               end else begin
                  if (m_cnt == 0) begin m_term = 1'b1; m_cnt = HOLD ? 0 : MAXC; end
                  else m_cnt = m_cnt - 1;
               end
            end
         end
      end
   end

   int term_tot = 0;
   int seen_tot = 0;
   always @(negedge clk) begin
      if (model_ok) begin
         chk("count",     32'(bus.count),     32'(m_cnt));
         chk("terminal",  32'(bus.terminal),  32'(m_term));
         chk("step_seen", 32'(bus.step_seen), 32'(m_seen));
      end
      if (bus.terminal === 1'b1)  term_tot++;
      if (bus.step_seen === 1'b1) seen_tot++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse();
      bus.clock_slow = 1'b1; tick(); tick();
      bus.clock_slow = 1'b0; tick(); tick();
   endtask

   task automatic do_load(input int v);
      bus.load = 1'b1; bus.load_value = WIDTH'(v); tick();
      bus.load = 1'b0;
   endtask

   initial begin
      int t0, s0;
      bus.clock_slow = 1'b0; bus.enable = 1'b1; bus.up_down = 1'b1;
      bus.load = 1'b0; bus.load_value = '0;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      chk("reset_count", 32'(bus.count), 0);
      chk("reset_term",  32'(bus.terminal), 0);
      chk("reset_seen",  32'(bus.step_seen), 0);

      // 4-high / 4-low square wave, ten periods
      t0 = term_tot;
      for (int p = 0; p < 10; p++) begin
         bus.clock_slow = 1'b1;
         for (int c = 0; c < 4; c++) begin
            tick();
            if (p == 0 && c == 1) chk("latency_k1_seen", 32'(bus.step_seen), 0);
            if (p == 0 && c == 2) begin
               chk("latency_k2_seen",  32'(bus.step_seen), 1);
               chk("latency_k2_count", 32'(bus.count), 1);
            end
         end
         bus.clock_slow = 1'b0;
         repeat (4) tick();
      end
      chk("square_final", 32'(bus.count), HOLD ? 9 : 0);
      chk("square_terms", 32'(term_tot - t0), 1);

      // down-step from zero
      do_load(0);
      bus.up_down = 1'b0;
      t0 = term_tot;
      pulse();
      chk("down_from_0", 32'(bus.count), HOLD ? 0 : 9);
      chk("down_term",   32'(term_tot - t0), 1);

      do_load(13);
      chk("load_clamp", 32'(bus.count), 9);

      // load coinciding with a step cycle
      bus.clock_slow = 1'b1; tick(); tick();
      bus.load = 1'b1; bus.load_value = 4'd5; tick();
      bus.load = 1'b0;
      chk("load_vs_step_count", 32'(bus.count), 5);
      chk("load_vs_step_term",  32'(bus.terminal), 0);
      chk("load_vs_step_seen",  32'(bus.step_seen), 1);
      bus.clock_slow = 1'b0; tick(); tick();

      // disabled edges are lost
      bus.up_down = 1'b1; bus.enable = 1'b0;
      s0 = seen_tot;
      repeat (3) pulse();
      chk("disabled_count", 32'(bus.count), 5);
      chk("disabled_seen",  32'(seen_tot - s0), 3);
      bus.enable = 1'b1;
      pulse();
      chk("reenable_count", 32'(bus.count), 6);

      // direction toggling from 5
      do_load(5);
      bus.up_down = 1'b1; pulse(); chk("toggle_1", 32'(bus.count), 6);
      bus.up_down = 1'b0; pulse(); chk("toggle_2", 32'(bus.count), 5);
      bus.up_down = 1'b1; pulse(); chk("toggle_3", 32'(bus.count), 6);
      bus.up_down = 1'b0; pulse(); chk("toggle_4", 32'(bus.count), 5);

      // reset mid-run at 6 with an edge in progress
      bus.up_down = 1'b1; pulse();
      chk("pre_reset_6", 32'(bus.count), 6);
      bus.clock_slow = 1'b1; tick();
      rst = 1'b1; tick();
      chk("mid_reset_count", 32'(bus.count), 0);
      rst = 1'b0; tick(); tick();
      bus.clock_slow = 1'b0; repeat (3) tick();
      chk("edge_discarded", 32'(bus.count), 0);

      // clock_slow held high through reset
      bus.clock_slow = 1'b1; rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      s0 = seen_tot;
      repeat (6) tick();
      chk("held_high_count", 32'(bus.count), 0);
      chk("held_high_seen",  32'(seen_tot - s0), 0);
      bus.clock_slow = 1'b0; repeat (3) tick();
      pulse();
      chk("after_held_count", 32'(bus.count), 1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bus.clock_slow = 1'($urandom_range(0, 1));
         bus.enable     = ($urandom_range(0, 9) != 0);
         bus.up_down    = 1'($urandom_range(0, 1));
         bus.load       = ($urandom_range(0, 29) == 0);
         bus.load_value = WIDTH'($urandom_range(0, 15));
         rst            = ($urandom_range(0, 149) == 0);
         tick();
      end
      rst = 1'b0; bus.load = 1'b0;
      repeat (4) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
